srm_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the Simple RISC Machine CPU control FSM and instruction register. It owns the program counter and issues reads to the 1-cycle-latency synchronous instruction RAM. It presents each fetched instruction to the CPU over a valid/ready handshake, accepts branch redirects from the CPU, and stops fetching after delivering a HALT instruction.

---
 rtl/srm_fetch_unit_pkg.sv | 25 ++
 rtl/srm_fetch_unit_pc_reg.sv | 40 ++++
 rtl/srm_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_srm_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/srm_fetch_unit_pkg.sv
// Shared definitions for the SRM instruction fetch stage: widths, defaults,
// the fetch FSM state encoding and the HALT opcode decode helper.
package srm_fetch_unit_pkg;

    localparam int unsigned INSTR_W          = 16;
    localparam int unsigned DEFAULT_ADDR_W   = 8;
    localparam int unsigned DEFAULT_RESET_PC = 0;
    localparam logic [2:0]  HALT_OPCODE      = 3'b111;

    // Fetch FSM states, binary encoded; unused codes recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_RESP   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

    // True when the opcode field instr[15:13] matches the halt opcode.
    function automatic logic is_halt(input logic [INSTR_W-1:0] instr,
                                     input logic [2:0]         op);
        return (instr[15:13] == op);
    endfunction

endpackage

// File: rtl/srm_fetch_unit_pc_reg.sv
// Program counter register: sync reset, load (branch redirect) and
// increment, with load taking priority over increment. Wraps modulo 2^ADDR_W.
module srm_pc_reg #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: redirect target wins over +1, otherwise hold.
    always_comb begin
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC storage with synchronous reset to the boot address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/srm_fetch_unit.sv
// Instruction fetch stage for the Simple RISC Machine. Reads the 1-cycle
// synchronous instruction RAM, buffers one instruction for the CPU behind a
// valid/ready handshake, follows branch redirects and stops after HALT.
module srm_fetch_unit
    import srm_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [2:0]        HALT_OP  = HALT_OPCODE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               w,
    output logic               halted
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    fetch_state_e resume_s;

    logic [INSTR_W-1:0] instr_out_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               instr_valid_q;
    logic               mem_rd_q;
    logic               w_q;
    logic               halted_q;

    logic [ADDR_W-1:0]  pc_s;
    logic               pc_load_s;
    logic               pc_inc_s;
    logic               capture_s;
    logic               clear_valid_s;
    logic               halt_s;

    assign halt_s   = is_halt(instr_out_q, HALT_OP);
    // After a redirect or a delivered instruction, fetch again only if enabled.
    assign resume_s = run ? ST_REQ : ST_IDLE;

    // Next-state and datapath control; redirect outranks normal progress,
    // except that a delivered HALT always wins and drops the redirect target.
    always_comb begin
        state_d       = state_q;
        pc_load_s     = 1'b0;
        pc_inc_s      = 1'b0;
        capture_s     = 1'b0;
        clear_valid_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pc_load_s = redirect;
                state_d   = resume_s;
            end
            ST_REQ: begin
                if (redirect) begin
                    // Outstanding read is abandoned; reissue at the target.
                    pc_load_s = 1'b1;
                    state_d   = resume_s;
                end else begin
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (redirect) begin
                    // Returning data belongs to the wrong path: drop it.
                    pc_load_s = 1'b1;
                    state_d   = resume_s;
                end else begin
                    capture_s = 1'b1;
                    pc_inc_s  = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    clear_valid_s = 1'b1;
                    if (halt_s) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_load_s = redirect;
                        state_d   = resume_s;
                    end
                end else if (redirect) begin
                    // Squash the undelivered instruction.
                    clear_valid_s = 1'b1;
                    pc_load_s     = 1'b1;
                    state_d       = resume_s;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, instruction buffer and registered status/strobe outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_out_q   <= {INSTR_W{1'b0}};
            instr_pc_q    <= {ADDR_W{1'b0}};
            instr_valid_q <= 1'b0;
            mem_rd_q      <= 1'b0;
            w_q           <= 1'b1;
            halted_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_rd_q <= (state_d == ST_REQ);
            w_q      <= (state_d == ST_IDLE);
            halted_q <= (state_d == ST_HALTED);
            if (capture_s) begin
                instr_out_q   <= mem_rdata;
                instr_pc_q    <= pc_s;
                instr_valid_q <= 1'b1;
            end else if (clear_valid_s) begin
                instr_valid_q <= 1'b0;
            end else begin
                instr_valid_q <= instr_valid_q;
            end
        end
    end

    srm_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load_s),
        .load_val_i (redirect_pc),
        .inc_i      (pc_inc_s),
        .pc_o       (pc_s)
    );

    assign mem_addr    = pc_s;
    assign mem_rd      = mem_rd_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign w           = w_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_srm_fetch_unit.sv
// Self-checking bench for srm_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level model of the fetch protocol.
module tb_srm_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        w;
    logic        halted;

    logic [15:0] mem [256];

    int n_chk  = 0;
    int n_pass = 0;
    bit check_en = 1'b0;

    // Reference model state
    logic [7:0]  m_pc;
    logic [15:0] m_out;
    logic [7:0]  m_ipc;
    bit          m_valid, m_halt, m_rd, m_infl;

    srm_fetch_unit #(.ADDR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .w           (w),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction RAM, one cycle read latency
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    endtask

    // Model: one fetch is a read (m_rd), then the data returning (m_infl),
    // then the instruction waiting for the CPU (m_valid).
    always @(posedge clk) begin
        if (reset) begin
            m_pc = 8'h00; m_out = 16'h0000; m_ipc = 8'h00;
            m_valid = 0; m_halt = 0; m_rd = 0; m_infl = 0;
        end else if (m_halt) begin
            m_rd = 0;
        end else if (m_rd) begin
            m_rd = 0;
            if (redirect) begin m_pc = redirect_pc; m_rd = run; end
            else m_infl = 1;
        end else if (m_infl) begin
            m_infl = 0;
            if (redirect) begin m_pc = redirect_pc; m_rd = run; end
            else begin m_out = mem[m_pc]; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 8'd1; end
        end else if (m_valid) begin
            if (instr_ready) begin
                m_valid = 0;
                if (m_out[15:13] == 3'b111) m_halt = 1;
                else begin
                    if (redirect) m_pc = redirect_pc;
                    m_rd = run;
                end
            end else if (redirect) begin
                m_valid = 0; m_pc = redirect_pc; m_rd = run;
            end
        end else begin
            if (redirect) m_pc = redirect_pc;
            m_rd = run;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("mem_addr", {24'h0, mem_addr}, {24'h0, m_pc});
            chk("mem_rd", {31'h0, mem_rd}, {31'h0, m_rd});
            chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
            chk("instr_out", {16'h0, instr_out}, {16'h0, m_out});
            chk("instr_pc", {24'h0, instr_pc}, {24'h0, m_ipc});
            chk("w", {31'h0, w}, {31'h0, !(m_rd || m_infl || m_valid || m_halt)});
            chk("halted", {31'h0, halted}, {31'h0, m_halt});
        end
    end

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            if (v[15:13] == 3'b111 && ($urandom % 4) != 0) v[15:13] = 3'b011;
            mem[i] = v;
        end
        mem[0] = 16'hD105; mem[1] = 16'h2345; mem[2] = 16'hE000;
        mem[8'h40] = 16'h1234; mem[8'hFF] = 16'h4321;

        reset = 1; run = 0; instr_ready = 0; redirect = 0; redirect_pc = 8'h00;
        @(posedge clk); #1 check_en = 1;

        // First fetch from RESET_PC
        @(negedge clk); reset = 0; run = 1;
        @(negedge clk);
        chk("t1_rd", {31'h0, mem_rd}, 32'd1);
        chk("t1_addr", {24'h0, mem_addr}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_valid", {31'h0, instr_valid}, 32'd1);
        chk("t1_out", {16'h0, instr_out}, 32'hD105);
        chk("t1_ipc", {24'h0, instr_pc}, 32'h0);
        chk("t1_pc", {24'h0, mem_addr}, 32'h1);

        // Back-pressure: five cycles with ready low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", {31'h0, instr_valid}, 32'd1);
            chk("t2_hold_out", {16'h0, instr_out}, 32'hD105);
            chk("t2_hold_rd", {31'h0, mem_rd}, 32'd0);
            chk("t2_hold_pc", {24'h0, mem_addr}, 32'h1);
        end
        instr_ready = 1;
        @(negedge clk);
        chk("t2_next_rd", {31'h0, mem_rd}, 32'd1);
        chk("t2_next_addr", {24'h0, mem_addr}, 32'h1);

        // Redirect during RESP squashes the fetch
        @(negedge clk);
        redirect = 1; redirect_pc = 8'h40;
        @(negedge clk);
        redirect = 0;
        chk("t3_squash_valid", {31'h0, instr_valid}, 32'd0);
        chk("t3_rd", {31'h0, mem_rd}, 32'd1);
        chk("t3_addr", {24'h0, mem_addr}, 32'h40);
        @(negedge clk);
        @(negedge clk);
        chk("t3_out", {16'h0, instr_out}, 32'h1234);
        chk("t3_ipc", {24'h0, instr_pc}, 32'h40);

        // Redirect with ready high in HOLD: delivered, then fetch HALT at 2
        redirect = 1; redirect_pc = 8'h02;
        @(negedge clk);
        redirect = 0;
        chk("t4_addr", {24'h0, mem_addr}, 32'h2);
        @(negedge clk);
        @(negedge clk);
        chk("t4_halt_out", {16'h0, instr_out}, 32'hE000);
        chk("t4_halt_valid", {31'h0, instr_valid}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            redirect = (i % 3 == 0); redirect_pc = 8'h10;
            chk("t4_halted", {31'h0, halted}, 32'd1);
            chk("t4_no_rd", {31'h0, mem_rd}, 32'd0);
            @(negedge clk);
        end
        redirect = 0;
        reset = 1;
        @(negedge clk);
        chk("t4_rst_halted", {31'h0, halted}, 32'd0);
        chk("t4_rst_w", {31'h0, w}, 32'd1);
        chk("t4_rst_addr", {24'h0, mem_addr}, 32'h0);

        // PC wrap from 0xFF
        reset = 0; run = 0;
        @(negedge clk);
        chk("t5_idle_w", {31'h0, w}, 32'd1);
        run = 1; redirect = 1; redirect_pc = 8'hFF; instr_ready = 0;
        @(negedge clk);
        redirect = 0;
        chk("t5_addr", {24'h0, mem_addr}, 32'hFF);
        @(negedge clk);
        @(negedge clk);
        chk("t5_ipc", {24'h0, instr_pc}, 32'hFF);
        chk("t5_wrap", {24'h0, mem_addr}, 32'h0);
        chk("t5_out", {16'h0, instr_out}, 32'h4321);

        // Reset while holding a valid instruction
        reset = 1;
        @(negedge clk);
        chk("t6_valid", {31'h0, instr_valid}, 32'd0);
        chk("t6_w", {31'h0, w}, 32'd1);
        chk("t6_addr", {24'h0, mem_addr}, 32'h0);
        chk("t6_rd", {31'h0, mem_rd}, 32'd0);
        reset = 0; run = 0;
        @(negedge clk);
        chk("t6_idle_rd", {31'h0, mem_rd}, 32'd0);
        @(negedge clk);
        chk("t6_idle_rd2", {31'h0, mem_rd}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            run         = ($urandom % 8) != 0;
            instr_ready = ($urandom % 3) != 0;
            redirect    = ($urandom % 10) == 0;
            redirect_pc = 8'($urandom);
            reset       = (($urandom % 300) == 0) || (m_halt && ($urandom % 4) == 0);
            @(negedge clk);
        end
        reset = 0;
        @(negedge clk);
        check_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
